bcd_scan_counter: RTL

//  Parametrised successor to the single-digit seconds counter. Prescales clk to a tick and

---
 rtl/bcd_scan_counter_pkg.sv | 31 +++
 rtl/bcd_scan_counter_if.sv | 31 +++
 rtl/bcd_digit_cell.sv | 39 +++
 rtl/bcd_scan_counter.sv | 110 +++++++++++
 4 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// Shared types, segment patterns and the seg7 decoder
// for the multi-digit BCD scan counter.
package bcd_scan_counter_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam int DEFAULT_MAX_COUNT = 10_000_000;

  localparam seg_t SEG_BLANK = 7'b000_0000;

  // {g,f,e,d,c,b,a}, active-high
  localparam seg_t SEG_DIGIT [10] = '{
    7'b011_1111,
    7'b000_0110,
    7'b101_1011,
    7'b100_1111,
    7'b110_0110,
    7'b110_1101,
    7'b111_1101,
    7'b000_0111,
    7'b111_1111,
    7'b110_1111
  };

  function automatic seg_t seg7(bcd_t d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle of the BCD scan counter.
// master = board/test side, slave = counter.
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          cmp_in;
  logic                run;
  logic                up_down;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd_out;
  logic                tick;
  logic                wrap;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   digit_sel;
  logic [7:0]          pre_lsb;

  modport master (
    output cmp_in, run, up_down,
    output load, load_val,
    input  bcd_out, tick, wrap,
    input  seg, digit_sel, pre_lsb
  );

  modport slave (
    input  cmp_in, run, up_down,
    input  load, load_val,
    output bcd_out, tick, wrap,
    output seg, digit_sel, pre_lsb
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD nibble with load, increment and decrement;
// carry/borrow ripple to the next cell.
module bcd_digit_cell
  import bcd_scan_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic carry_out,
  output logic borrow_out
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (d > 4'd9) ? 4'd0 : d;
    end else if (inc) begin
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q          = q_q;
  assign carry_out  = inc && (q_q == 4'd9);
  assign borrow_out = dec && (q_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Prescaled up/down BCD counter with load/pause and a
// time-multiplexed 7-segment digit scan.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE_W = 24,
  parameter int MAX_COUNT  = DEFAULT_MAX_COUNT,
  parameter int SCAN_DIV   = 1024
) (
  input  logic clk,
  input  logic reset,
  bcd_scan_counter_if.slave bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PRESCALE_W-1:0] cnt_q, cnt_d, cmp_val;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  term;
  logic                  adv;
  logic [DIGITS:0]       cin, bin;
  logic [4*DIGITS-1:0]   bcd;

  always_comb begin
    cmp_val = (bus.cmp_in == 8'd0)
      ? PRESCALE_W'(MAX_COUNT)
      : PRESCALE_W'({bus.cmp_in, 10'b0});
  end

  // >= so lowering cmp_in mid-count fires at once
  assign term = bus.run && (cnt_q >= cmp_val);
  assign adv  = term && !bus.load;

  assign cin[0] = adv && bus.up_down;
  assign bin[0] = adv && !bus.up_down;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .inc        (cin[i]),
      .dec        (bin[i]),
      .load       (bus.load),
      .d          (bus.load_val[4*i +: 4]),
      .q          (bcd[4*i +: 4]),
      .carry_out  (cin[i+1]),
      .borrow_out (bin[i+1])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = '0;
    end else if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      wrap_d = cin[DIGITS] | bin[DIGITS];
    end else if (bus.run) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    sel_d  = sel_q;
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = (sel_q << 1) | (sel_q >> (DIGITS - 1));
      idx_d  = (idx_q == IDX_W'(DIGITS - 1))
        ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      scan_q <= '0;
      sel_q  <= DIGITS'(1);
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      scan_q <= scan_d;
      sel_q  <= sel_d;
      idx_q  <= idx_d;
    end
  end

  assign bus.bcd_out   = bcd;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.digit_sel = sel_q;
  assign bus.pre_lsb   = cnt_q[7:0];
  assign bus.seg       = seg7(bcd[4*idx_q +: 4]);

endmodule
